// File: rtl/pd_seq_pkg.sv
// Shared types and width helpers for the power-domain sequencer.
package pd_seq_pkg;

  localparam int unsigned MAX_PD   = 8;
  localparam int unsigned PD_IDX_W = $clog2(MAX_PD);

  // Domain index wide enough for the largest supported configuration.
  typedef logic [PD_IDX_W-1:0] pd_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BLANK,
    ST_WAIT,
    ST_SETTLE
  } seq_state_e;

  // Timeout counter only has to reach TIMEOUT_CYCLES-1.
  function automatic int unsigned tcnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles);
  endfunction

  // Settle counter holds SETTLE_CYCLES-1 with one bit of headroom.
  function automatic int unsigned scnt_width(input int unsigned settle_cycles);
    return $clog2(settle_cycles) + 1;
  endfunction

endpackage

// File: rtl/pd_rr_arbiter.sv
// Combinational round-robin pick; the priority class (power-downs) wins when non-empty.
module pd_rr_arbiter #(
  parameter int unsigned NUM_PD = 4,
  localparam int unsigned IDX_W = $clog2(NUM_PD)
) (
  input  logic [NUM_PD-1:0] req,
  input  logic [NUM_PD-1:0] cls,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_PD-1:0] gnt_c,
  output logic [IDX_W-1:0]  idx_c
);

  logic [NUM_PD-1:0] eff;
  logic              found;
  logic [IDX_W-1:0]  pos;

  // Search starts one past the last served index and wraps around.
  always_comb begin
    eff   = ((req & cls) != '0) ? (req & cls) : req;
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 1; k <= NUM_PD; k++) begin
      pos = IDX_W'((32'(ptr) + k) % NUM_PD);
      if (!found && eff[pos]) begin
        found      = 1'b1;
        gnt_c[pos] = 1'b1;
        idx_c      = pos;
      end
    end
  end

endmodule

// File: rtl/pd_power_sequencer.sv
// Serialises APC power transitions one domain at a time with settle gap and timeout.
module pd_power_sequencer
  import pd_seq_pkg::*;
#(
  parameter int unsigned       NUM_PD         = 4,
  parameter logic [NUM_PD-1:0] RESET_STATE    = NUM_PD'(4'b0001),
  parameter int unsigned       SETTLE_CYCLES  = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  localparam int unsigned      IDX_W          = $clog2(NUM_PD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PD-1:0] pd_target,
  output logic [NUM_PD-1:0] pd_power,
  input  logic [NUM_PD-1:0] apc_done,
  input  logic [NUM_PD-1:0] err_clr,
  output logic [NUM_PD-1:0] pd_status,
  output logic [NUM_PD-1:0] pd_err,
  output logic              busy,
  output logic [IDX_W-1:0]  cur_pd,
  output logic              xfer_done
);

  localparam int unsigned TCNT_W = tcnt_width(TIMEOUT_CYCLES);
  localparam int unsigned SCNT_W = scnt_width(SETTLE_CYCLES);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d, ptr_q, ptr_d;
  logic [NUM_PD-1:0] power_q, power_d, status_q, status_d, err_q, err_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              xfer_q, xfer_d, busy_q;

  logic [NUM_PD-1:0] pend, down, gnt;
  logic [IDX_W-1:0]  gnt_idx;

  // Errored domains drop out of arbitration until software clears them.
  assign pend = (pd_target ^ status_q) & ~err_q;
  assign down = status_q & ~pd_target;

  pd_rr_arbiter #(.NUM_PD(NUM_PD)) u_arb (
    .req   (pend),
    .cls   (down),
    .ptr   (ptr_q),
    .gnt_c (gnt),
    .idx_c (gnt_idx)
  );

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    ptr_d    = ptr_q;
    power_d  = power_q;
    status_d = status_q;
    err_d    = err_q & ~err_clr;
    tcnt_d   = tcnt_q;
    scnt_d   = scnt_q;
    xfer_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != '0) begin
          cur_d   = gnt_idx;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        power_d[cur_q] = pd_target[cur_q];
        tcnt_d         = '0;
        state_d        = ST_BLANK;
      end
      // Covers the wrapper's input register; done is not looked at here.
      ST_BLANK: state_d = ST_WAIT;
      ST_WAIT: begin
        if (apc_done[cur_q]) begin
          status_d[cur_q] = power_q[cur_q];
          xfer_d          = 1'b1;
          scnt_d          = SCNT_W'(SETTLE_CYCLES - 1);
          state_d         = ST_SETTLE;
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d[cur_q] = 1'b1;
          scnt_d       = SCNT_W'(SETTLE_CYCLES - 1);
          state_d      = ST_SETTLE;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (scnt_q == '0) begin
          ptr_d   = cur_q;
          state_d = ST_IDLE;
        end else begin
          scnt_d = scnt_q - SCNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      ptr_q    <= '0;
      power_q  <= RESET_STATE;
      status_q <= RESET_STATE;
      err_q    <= '0;
      tcnt_q   <= '0;
      scnt_q   <= '0;
      xfer_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      power_q  <= power_d;
      status_q <= status_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
      xfer_q   <= xfer_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign pd_power  = power_q;
  assign pd_status = status_q;
  assign pd_err    = err_q;
  assign busy      = busy_q;
  assign cur_pd    = cur_q;
  assign xfer_done = xfer_q;

endmodule

// File: tb/tb_pd_power_sequencer.sv
// Scoreboard bench for pd_power_sequencer with a rule-level reference model.
module tb_pd_power_sequencer;

  localparam int unsigned N      = 4;
  localparam logic [3:0]  RST_ST = 4'b0001;
  localparam int          S      = 16;
  localparam int          T      = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pd_target, pd_power, apc_done, err_clr, pd_status, pd_err;
  logic       busy, xfer_done;
  logic [1:0] cur_pd;

  always #5 clk = ~clk;

  pd_power_sequencer #(
    .NUM_PD(N), .RESET_STATE(RST_ST), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .pd_target(pd_target), .pd_power(pd_power),
    .apc_done(apc_done), .err_clr(err_clr), .pd_status(pd_status),
    .pd_err(pd_err), .busy(busy), .cur_pd(cur_pd), .xfer_done(xfer_done)
  );

  typedef struct {
    int         idx;
    bit         is_err;
    logic [3:0] status;
    logic [3:0] vec;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_power, m_status, m_err, m_target, stuck_mask;
  int         m_ptr;
  bit         mon_en = 1'b0;
  bit         toggle_once = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_power = RST_ST; m_status = RST_ST; m_err = '0; m_ptr = 0;
  endtask

  function automatic logic [3:0] m_pend();
    return (m_target ^ m_status) & ~m_err;
  endfunction

  // Downs before ups; each class scanned from the slot after the last served one.
  function automatic int m_pick();
    logic [3:0] p  = m_pend();
    logic [3:0] dn = p & m_status;
    for (int k = 1; k <= 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (dn[i]) return i;
    end
    for (int k = 1; k <= 4; k++) begin
      int i = (m_ptr + k) % 4;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: pops an expectation on each completion pulse or new error flag.
  initial begin
    logic [3:0] prev, rose;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      rose = pd_err & ~prev;
      if (mon_en) begin
        if (xfer_done) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected_xfer: cur_pd=%0d with empty queue at %0t", cur_pd, $time);
          end else begin
            e = q.pop_front();
            chk("sb_xfer_kind", 32'(e.is_err), 32'(1'b0));
            chk("sb_xfer_idx", 32'(cur_pd), 32'(e.idx));
            chk("sb_xfer_status", 32'(pd_status), 32'(e.status));
            chk("sb_xfer_power", 32'(pd_power), 32'(e.vec));
          end
        end
        if (rose != '0) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected_err: pd_err=%0h with empty queue at %0t", pd_err, $time);
          end else begin
            e = q.pop_front();
            chk("sb_err_kind", 32'(e.is_err), 32'(1'b1));
            chk("sb_err_idx", 32'(cur_pd), 32'(e.idx));
            chk("sb_err_vec", 32'(pd_err), 32'(e.vec));
            chk("sb_err_status", 32'(pd_status), 32'(e.status));
          end
        end
      end
      prev = pd_err;
    end
  end

  // Plays the APC side of one transition; cycle 0 is the launch cycle.
  task automatic serve();
    int         w, k, c, fall_c, err_c, exp_fall;
    bit         stuck;
    logic       newv;
    logic [3:0] ns, np;
    exp_t       e;
    w     = m_pick();
    stuck = stuck_mask[w];
    k     = 2 + int'($urandom_range(0, 6));
    newv  = m_target[w];
    ns = m_status; ns[w] = newv;
    np = m_power;  np[w] = newv;
    e.idx = w; e.is_err = stuck;
    e.status = stuck ? m_status : ns;
    e.vec    = stuck ? (m_err | 4'(1 << w)) : np;
    q.push_back(e);
    c = 0;
    do begin @(negedge clk); c++; end while (!busy && c < 100);
    if (!busy) begin
      chk("launch_seen", 32'(busy), 32'd1);
      q.delete();
      return;
    end
    chk("cur_pd_pick", 32'(cur_pd), 32'(w));
    c = 0; fall_c = -1; err_c = -1;
    while (c < T + S + 40) begin
      @(negedge clk); c++;
      apc_done = '0;
      if (err_c < 0 && pd_err[w]) err_c = c;
      if (!busy) begin fall_c = c; break; end
      if (c >= 2) apc_done = 4'($urandom) & ~4'(1 << w);
      if (stuck && c == 1) apc_done[w] = 1'b1;
      if (!stuck && c == k) apc_done[w] = 1'b1;
      if (toggle_once && c == 3) begin
        toggle_once = 1'b0;
        m_target[w] = ~m_target[w];
        pd_target   = m_target;
      end
    end
    apc_done = '0;
    exp_fall = stuck ? (T + 2 + S) : (k + 1 + S);
    chk("busy_fall_cycle", 32'(fall_c), 32'(exp_fall));
    if (stuck) chk("timeout_cycle", 32'(err_c), 32'(T + 2));
    m_power = np;
    if (stuck) m_err[w] = 1'b1;
    else       m_status = ns;
    m_ptr = w;
    chk("pd_power", 32'(pd_power), 32'(m_power));
    chk("pd_status", 32'(pd_status), 32'(m_status));
    chk("pd_err", 32'(pd_err), 32'(m_err));
  endtask

  task automatic run_round(input logic [3:0] tgt, input logic [3:0] stk);
    int guard = 0;
    m_target = tgt; pd_target = tgt; stuck_mask = stk;
    while (m_pend() != '0 && guard < 12) begin serve(); guard++; end
    repeat (2) @(negedge clk);
    chk("idle_after_round", 32'(busy), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic clear_err(input logic [3:0] m);
    err_clr = m;
    @(negedge clk);
    err_clr = '0;
    m_err &= ~m;
    chk("err_clr", 32'(pd_err), 32'(m_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pd_target = RST_ST; apc_done = '0; err_clr = '0; stuck_mask = '0;
    m_target = RST_ST;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_power", 32'(pd_power), 32'(RST_ST));
    chk("rst_status", 32'(pd_status), 32'(RST_ST));
    chk("rst_err", 32'(pd_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_pd", 32'(cur_pd), 32'd0);
    chk("rst_xfer", 32'(xfer_done), 32'd0);
    rst = 1'b1; mon_en = 1'b1;
    @(negedge clk);

    run_round(4'b0011, 4'b0000);
    run_round(4'b1100, 4'b0000);
    run_round(4'b0000, 4'b0000);
    run_round(4'b0110, 4'b0100);
    chk("pd2_status_after_timeout", 32'(pd_status[2]), 32'd0);
    clear_err(4'b0100);
    run_round(4'b0110, 4'b0000);
    toggle_once = 1'b1;
    run_round(4'b0100, 4'b0000);
    run_round(4'b1110, 4'b1000);

    // Asynchronous reset while a transition is waiting for done.
    pd_target = 4'b0010;
    begin
      int c = 0;
      do begin @(negedge clk); c++; end while (!busy && c < 100);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_power", 32'(pd_power), 32'(RST_ST));
    chk("midrst_status", 32'(pd_status), 32'(RST_ST));
    chk("midrst_err", 32'(pd_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cur_pd", 32'(cur_pd), 32'd0);
    q.delete();
    @(negedge clk);
    pd_target = RST_ST; m_target = RST_ST;
    model_reset();
    rst = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    run_round(4'b0011, 4'b0000);

    for (int r = 0; r < 25; r++) begin
      logic [3:0] tgt, stk;
      tgt = 4'($urandom);
      stk = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      run_round(tgt, stk);
      if (m_err != '0 && $urandom_range(0, 1) == 1) begin
        clear_err(m_err);
        run_round(m_target, 4'b0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pd_power_sequencer.md
Name: pd_power_sequencer

Overview:
- Sequences power-domain on/off transitions across NUM_PD APC wrapper instances, one domain at a time.
- Limits inrush and serialises APC handshakes.
- Software writes a target power vector. The block drives each APC wrapper's `power` input, waits for its `done`, enforces a settle gap, and flags domains whose handshake times out.
- Sits between the SoC power-management registers and the per-domain APC wrappers.

Parameters:
NUM_PD, 4, number of controlled power domains (2..8)
RESET_STATE, 4'b0001, per-domain power state after reset (bit i = domain i on)
SETTLE_CYCLES, 16, idle cycles enforced after each completed transition (>=1)
TIMEOUT_CYCLES, 1024, max cycles to wait for apc_done before error (>=4)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
pd_target  input  NUM_PD  requested power state per domain (1 = on)
pd_power  output  NUM_PD  drives `power` of each APC wrapper
apc_done  input  NUM_PD  `done` from each APC wrapper
err_clr  input  NUM_PD  per-domain pulse, clears pd_err bit
pd_status  output  NUM_PD  committed (acknowledged) power state
pd_err  output  NUM_PD  sticky timeout flag per domain
busy  output  1  high while any transition is in flight or settling
cur_pd  output  $clog2(NUM_PD)  index of domain being served (valid when busy)
xfer_done  output  1  one-cycle pulse when a transition completes successfully

Behaviour:
- Clock and reset: one clock; reset is asynchronous active-low on `rst`.
- Reset values:
  - pd_power = pd_status = RESET_STATE.
  - pd_err = 0, busy = 0, cur_pd = 0, xfer_done = 0.
  - FSM in IDLE, round-robin pointer at 0.
- Pending vector: pend = (pd_target ^ pd_status) & ~pd_err.
- Arbitration:
  - Pending power-downs (pd_status=1, pd_target=0) have strict priority over power-ups.
  - Within a class, round-robin starting at (last served index + 1) mod NUM_PD.
- FSM IDLE:
  - If pend != 0, latch the winner into cur_pd and go to LAUNCH.
  - Otherwise stay in IDLE with busy = 0.
- FSM LAUNCH (1 cycle):
  - pd_power[cur_pd] <= pd_target[cur_pd].
  - Clear the timeout counter, then go to BLANK.
- FSM BLANK (1 cycle):
  - apc_done is ignored; this covers the APC wrapper's power_d register latency.
  - Go to WAIT.
- FSM WAIT:
  - On apc_done[cur_pd]=1: pd_status[cur_pd] <= pd_power[cur_pd]; pulse xfer_done; load the settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: set pd_err[cur_pd]=1; pd_status is not updated; pd_power is left at the new value; go to SETTLE.
- FSM SETTLE: count down to 0, then go to IDLE and advance the RR pointer to cur_pd.
- busy = (state != IDLE).
- Transitions are never preempted.
- pd_target changes on the in-flight domain take effect only after return to IDLE, where the domain re-arbitrates. A target toggling back yields a second, opposite transition.
- apc_done of non-selected domains is ignored.
- err_clr[i]:
  - Clears pd_err[i] next cycle, making the domain eligible again.
  - If err_clr[i] and a timeout setting pd_err[i] occur in the same cycle, the set wins.
- Errored domain retry: on re-arbitration, LAUNCH rewrites the same pd_power value. The APC wrapper sees no edge, and done is sampled normally.
- Counters:
  - Width $clog2(TIMEOUT_CYCLES) and $clog2(SETTLE_CYCLES)+1.
  - Saturating; no wrap.
- Reset mid-operation returns all outputs to reset values immediately. pd_power jumps to RESET_STATE; the APC wrappers reset alongside.

Decomposition:
- Package pd_seq_pkg:
  - FSM state enum (IDLE, LAUNCH, BLANK, WAIT, SETTLE).
  - Counter width localparams.
  - PD index type.
- Sub-module pd_rr_arbiter:
  - Inputs: request vector, priority-class mask, pointer.
  - Outputs: one-hot grant plus encoded index; purely combinational.
  - Instantiated once.
- FSM, counters and status registers live in pd_power_sequencer.

Test Plan:
- Reset with RESET_STATE=0001, then pd_target=0011 → LAUNCH on pd1 at cycle+1; pd_power=0011; apc_done[1] high 5 cycles later → pd_status=0011, xfer_done one pulse, busy low after SETTLE_CYCLES.
- pd_target changes from 0011 to 1100 (two downs, two ups) → service order pd0, pd1 (downs) then pd2, pd3. At least SETTLE_CYCLES idle between launches; cur_pd sequence 0,1,2,3.
- Hold apc_done[2]=0 on a power-up of pd2 → pd_err=0100 at cycle TIMEOUT_CYCLES after WAIT entry; pd_status[2] stays 0; other pending domains still serviced. err_clr[2] pulse → pd2 re-launched.
- Toggle pd_target[1] during WAIT on pd1 → the first transition completes; after SETTLE, pd1 re-arbitrates and a reverse transition is launched.
- Assert apc_done on a non-selected domain during WAIT → ignored; no xfer_done and no status change.
- Drop rst during WAIT → pd_power, pd_status = RESET_STATE and pd_err = 0 immediately; busy=0; normal operation after release.
